// File: rtl/spi_status_tx_pkg.sv
// Shared types and frame layout for the SPI status transmitter.
// The frame is sent MSB first as {brush, color, pad, x, y, seq}.
package spi_status_pkg;

    localparam int FRAME_BITS = 32;
    localparam int BRUSH_MSB  = 31;
    localparam int COLOR_MSB  = 30;
    localparam int X_MSB      = 25;
    localparam int Y_MSB      = 15;
    localparam int SEQ_MSB    = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } tx_state_t;

    typedef struct packed {
        logic       brush;
        logic [2:0] color;
        logic [1:0] pad;
        logic [9:0] x;
        logic [9:0] y;
        logic [5:0] seq;
    } status_frame_t;

endpackage

// File: rtl/spi_status_tx_sync_edge.sv
// Multi-flop synchronizer for an asynchronous pin, followed by a registered
// previous-sample compare that produces single-cycle rise/fall pulses.
module sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic srst,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_reg;
    logic              prev_reg;

    // Reset to 0 so that a reset taken while cs is held low cannot fake a falling edge.
    always_ff @(posedge clk) begin
        if (srst) begin
            sync_reg[0] <= 1'b0;
        end else begin
            sync_reg[0] <= din;
        end
    end

    generate
        for (genvar gi = 1; gi < STAGES; gi++) begin : g_stage
            always_ff @(posedge clk) begin
                if (srst) begin
                    sync_reg[gi] <= 1'b0;
                end else begin
                    sync_reg[gi] <= sync_reg[gi-1];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (srst) begin
            prev_reg <= 1'b0;
        end else begin
            prev_reg <= sync_reg[STAGES-1];
        end
    end

    assign rise = sync_reg[STAGES-1] & ~prev_reg;
    assign fall = ~sync_reg[STAGES-1] & prev_reg;

endmodule

// File: rtl/spi_status_tx.sv
// MISO-side transmitter: snapshots the status shadow register on cs fall
// and shifts it out MSB first in SPI mode 0, all on the system clock.
module spi_status_tx
    import spi_status_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int SEQ_BITS    = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sck,
    input  logic       cs,
    output logic       sdo,
    input  logic       upd_valid,
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic       brush,
    input  logic [2:0] colorCode,
    output logic       busy,
    output logic       frame_done,
    output logic       frame_abort
);

    logic sck_rise;
    logic sck_fall;
    logic cs_rise;
    logic cs_fall;

    sync_edge #(.STAGES(SYNC_STAGES)) u_sck_sync (
        .clk  (clk),
        .srst (reset),
        .din  (sck),
        .rise (sck_rise),
        .fall (sck_fall)
    );

    sync_edge #(.STAGES(SYNC_STAGES)) u_cs_sync (
        .clk  (clk),
        .srst (reset),
        .din  (cs),
        .rise (cs_rise),
        .fall (cs_fall)
    );

    tx_state_t               state_reg;
    logic [5:0]              bit_cnt_reg;
    logic [FRAME_BITS-1:0]   shift_reg;
    logic                    sdo_reg;
    logic                    busy_reg;
    logic                    done_reg;
    logic                    abort_reg;
    logic [SEQ_BITS-1:0]     seq_reg;
    status_frame_t           shadow_reg;
    status_frame_t           upd_frame;
    status_frame_t           snap_frame;

    always_comb begin
        upd_frame       = '0;
        upd_frame.brush = brush;
        upd_frame.color = colorCode;
        upd_frame.x     = x;
        upd_frame.y     = y;

        // A same-cycle update wins over the stored shadow in the snapshot.
        snap_frame      = upd_valid ? upd_frame : shadow_reg;
        snap_frame.pad  = 2'b00;
        snap_frame.seq  = (SEQ_MSB + 1)'(seq_reg);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            bit_cnt_reg <= '0;
            shift_reg   <= '0;
            sdo_reg     <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            abort_reg   <= 1'b0;
            seq_reg     <= '0;
            shadow_reg  <= '0;
        end else begin
            done_reg  <= 1'b0;
            abort_reg <= 1'b0;
            if (upd_valid) begin
                shadow_reg <= upd_frame;
            end

            case (state_reg)
                IDLE: begin
                    sdo_reg  <= 1'b0;
                    busy_reg <= 1'b0;
                    if (cs_fall) begin
                        shift_reg   <= snap_frame;
                        bit_cnt_reg <= '0;
                        sdo_reg     <= snap_frame[FRAME_BITS-1];
                        busy_reg    <= 1'b1;
                        state_reg   <= SHIFT;
                    end
                end

                SHIFT: begin
                    if (cs_rise) begin
                        state_reg <= IDLE;
                        sdo_reg   <= 1'b0;
                        busy_reg  <= 1'b0;
                        abort_reg <= 1'b1;
                    end else if (sck_rise) begin
                        bit_cnt_reg <= bit_cnt_reg + 6'd1;
                        if (bit_cnt_reg == 6'(FRAME_BITS - 1)) begin
                            state_reg <= DONE;
                            sdo_reg   <= 1'b0;
                        end
                    end else if (sck_fall) begin
                        shift_reg <= {shift_reg[FRAME_BITS-2:0], 1'b0};
                        sdo_reg   <= shift_reg[FRAME_BITS-2];
                    end
                end

                DONE: begin
                    // bit_cnt stays at 32 here; further sck edges are ignored.
                    sdo_reg <= 1'b0;
                    if (cs_rise) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        seq_reg   <= seq_reg + 1'b1;
                    end
                end

                default: begin
                    state_reg <= IDLE;
                    sdo_reg   <= 1'b0;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign sdo         = sdo_reg;
    assign busy        = busy_reg;
    assign frame_done  = done_reg;
    assign frame_abort = abort_reg;

endmodule
